cpu_run_ctrl: RTL

Run/step/reset sequencer for the CPU core. It sits beside the clock manager on the 100 MHz board clock. It turns the board reset, a reset button, a step button and a run switch into a clean CPU reset and a qualified CPU clock-enable. It also keeps an executed-cycle count for the LED/segment display path. Free run, paced run and single-step debugging all happen without gating the clock itself.

---
 rtl/cpu_ctrl_pkg.sv | 19 +
 rtl/btn_debounce.sv | 60 ++++++
 rtl/cpu_run_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding for the CPU run/step/reset sequencer.
// The display path decodes `mode` with these same constants.
package cpu_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ST_RST_HOLD = 2'd0,
        ST_HALT     = 2'd1,
        ST_STEP     = 2'd2,
        ST_RUN      = 2'd3
    } run_state_e;

    // Counter width that still gives one bit for a terminal count of zero.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one raw push-button.
// PULSE=1 emits a one-cycle strobe on an accepted press, PULSE=0 the debounced level.
module btn_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DEB_CYC = 1_000_000,
    parameter bit PULSE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic q
);

    localparam int CW = cnt_width(DEB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          meta;
    logic          sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
        end
    end

    // A new level is taken only after DEB_CYC consecutive samples disagree with the current one.
    assign accept = (sync != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            q     <= 1'b0;
        end else begin
            if (sync == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= sync;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (PULSE) begin
                q <= accept & sync;
            end else begin
                q <= accept ? sync : level;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/reset sequencer: turns board reset, buttons and switches into a clean
// CPU reset and a qualified clock-enable, and counts issued enables.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV      = 50_000_000,
    parameter int RST_HOLD = 16,
    parameter int DEB_CYC  = 1_000_000
) (
    input  logic              clk_100M,
    input  logic              res,
    input  logic              btn_rst,
    input  logic              btn_step,
    input  logic              sw_run,
    input  logic              sw_fast,
    output logic              cpu_reset,
    output logic              cpu_ce,
    output logic [MODE_W-1:0] mode,
    output logic [31:0]       ce_cnt
);

    localparam int DW = cnt_width(DIV);
    localparam int HW = cnt_width(RST_HOLD);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    run_state_e    state;
    run_state_e    state_n;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_n;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_n;
    logic          ce_n;
    logic          reset_n;

    logic          run_meta;
    logic          run_s;
    logic          fast_meta;
    logic          fast_s;
    logic          rst_req;
    logic          step_evt;

    btn_debounce #(.DEB_CYC(DEB_CYC), .PULSE(1'b0)) u_deb_rst (
        .clk   (clk_100M),
        .rst_n (res),
        .btn   (btn_rst),
        .q     (rst_req)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC), .PULSE(1'b1)) u_deb_step (
        .clk   (clk_100M),
        .rst_n (res),
        .btn   (btn_step),
        .q     (step_evt)
    );

    // Switches bounce harmlessly for this use, so they are only synchronized.
    always_ff @(posedge clk_100M or negedge res) begin
        if (!res) begin
            run_meta  <= 1'b0;
            run_s     <= 1'b0;
            fast_meta <= 1'b0;
            fast_s    <= 1'b0;
        end else begin
            run_meta  <= sw_run;
            run_s     <= run_meta;
            fast_meta <= sw_fast;
            fast_s    <= fast_meta;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        div_n   = div_cnt;

        if (rst_req) begin
            state_n = ST_RST_HOLD;
            hold_n  = '0;
            div_n   = '0;
        end else begin
            case (state)
                ST_RST_HOLD: begin
                    div_n = '0;
                    if (hold_cnt == HOLD_LAST) begin
                        hold_n  = '0;
                        state_n = run_s ? ST_RUN : ST_HALT;
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end
                ST_HALT: begin
                    div_n = '0;
                    if (run_s) begin
                        state_n = ST_RUN;
                    end else if (step_evt) begin
                        state_n = ST_STEP;
                    end
                end
                ST_STEP: begin
                    state_n = ST_HALT;
                end
                ST_RUN: begin
                    // Fast mode parks the divider at zero, so a mode change always restarts pacing.
                    if (!run_s) begin
                        state_n = ST_HALT;
                        div_n   = '0;
                    end else if (fast_s || (div_cnt == DIV_LAST)) begin
                        div_n = '0;
                    end else begin
                        div_n = div_cnt + DW'(1);
                    end
                end
                default: begin
                    state_n = ST_RST_HOLD;
                    hold_n  = '0;
                    div_n   = '0;
                end
            endcase
        end

        ce_n    = (state_n == ST_STEP) ||
                  ((state_n == ST_RUN) && (fast_s || (div_n == DIV_LAST)));
        reset_n = (state_n == ST_RST_HOLD);
    end

    always_ff @(posedge clk_100M or negedge res) begin
        if (!res) begin
            state     <= ST_RST_HOLD;
            hold_cnt  <= '0;
            div_cnt   <= '0;
            cpu_reset <= 1'b1;
            cpu_ce    <= 1'b0;
            ce_cnt    <= '0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            div_cnt   <= div_n;
            cpu_reset <= reset_n;
            cpu_ce    <= ce_n;
            if (reset_n) begin
                ce_cnt <= '0;
            end else if (ce_n) begin
                ce_cnt <= ce_cnt + 32'd1;
            end
        end
    end

    assign mode = state;

endmodule
